// File: rtl/systolic_array.sv
// systolic_array: output-stationary ARRAY_HEIGHT x ARRAY_WIDTH MAC array computing C = A x B
module systolic_array #(
    parameter int PE_DATA_WIDTH_IN  = 32,
    parameter int PE_DATA_WIDTH_OUT = 32,
    parameter int ARRAY_WIDTH       = 7,
    parameter int ARRAY_HEIGHT      = 10
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         ctrl_start_i,
    input  logic [PE_DATA_WIDTH_IN-1:0]  active_i [0:ARRAY_HEIGHT-1],
    input  logic [PE_DATA_WIDTH_IN-1:0]  weight_i [0:ARRAY_WIDTH-1],
    output logic [PE_DATA_WIDTH_OUT-1:0] result_o [0:ARRAY_HEIGHT-1][0:ARRAY_WIDTH-1]
);
    logic [PE_DATA_WIDTH_IN-1:0] a_fwd [0:ARRAY_HEIGHT-1][0:ARRAY_WIDTH-1];
    logic [PE_DATA_WIDTH_IN-1:0] w_fwd [0:ARRAY_HEIGHT-1][0:ARRAY_WIDTH-1];
    for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_row
        for (genvar j = 0; j < ARRAY_WIDTH; j++) begin : g_col
            logic [PE_DATA_WIDTH_IN-1:0]  a_in, w_in, a_d, a_q, w_d, w_q;
            logic [PE_DATA_WIDTH_OUT-1:0] acc_d, acc_q;
            if (j == 0) begin : g_a_edge
                assign a_in = active_i[i];
            end else begin : g_a_int
                assign a_in = a_fwd[i][j-1];
            end
            if (i == 0) begin : g_w_edge
                assign w_in = weight_i[j];
            end else begin : g_w_int
                assign w_in = w_fwd[i-1][j];
            end
            // Start clears the PE; otherwise forward operands and accumulate their product modulo 2^OUT
            always_comb begin
                a_d   = ctrl_start_i ? '0 : a_in;
                w_d   = ctrl_start_i ? '0 : w_in;
                acc_d = ctrl_start_i ? '0 :
                        acc_q + PE_DATA_WIDTH_OUT'(a_in) * PE_DATA_WIDTH_OUT'(w_in);
            end
            // PE state registers, cleared asynchronously by reset
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    a_q   <= '0;
                    w_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_d;
                    w_q   <= w_d;
                    acc_q <= acc_d;
                end
            end
            assign a_fwd[i][j]    = a_q;
            assign w_fwd[i][j]    = w_q;
            assign result_o[i][j] = acc_q;
            if (j == ARRAY_WIDTH - 1) begin : g_a_sink
                logic unused_a;
                assign unused_a = ^a_q;
            end
            if (i == ARRAY_HEIGHT - 1) begin : g_w_sink
                logic unused_w;
                assign unused_w = ^w_q;
            end
        end
    end
endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: directed self-checking bench for the systolic matrix-multiply array
module tb_systolic_array;
    localparam int H = 10;
    localparam int W = 7;
    localparam int K = 5;
    localparam int LAST_N = K + H + W - 3;

    typedef struct {
        logic       st;
        logic [7:0] a;
        logic [7:0] w;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        int          i;
        int          j;
        int unsigned exp;
    } spot_t;

    logic        clk = 0;
    logic        rstn = 1;
    logic        start = 0;
    logic [31:0] act [0:H-1];
    logic [31:0] wt  [0:W-1];
    logic [31:0] res [0:H-1][0:W-1];
    logic        s_start = 0;
    logic [7:0]  s_act [0:0];
    logic [7:0]  s_wt  [0:0];
    logic [7:0]  s_res [0:0][0:0];

    int unsigned am [0:H-1][0:K-1];
    int unsigned bm [0:K-1][0:W-1];
    int unsigned cm [0:H-1][0:W-1];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_array #(.PE_DATA_WIDTH_IN(32), .PE_DATA_WIDTH_OUT(32), .ARRAY_WIDTH(W), .ARRAY_HEIGHT(H)) dut (
        .clk_i(clk), .rstn_i(rstn), .ctrl_start_i(start),
        .active_i(act), .weight_i(wt), .result_o(res)
    );

    systolic_array #(.PE_DATA_WIDTH_IN(8), .PE_DATA_WIDTH_OUT(8), .ARRAY_WIDTH(1), .ARRAY_HEIGHT(1)) dut_small (
        .clk_i(clk), .rstn_i(rstn), .ctrl_start_i(s_start),
        .active_i(s_act), .weight_i(s_wt), .result_o(s_res)
    );

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    task automatic model();
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                cm[i][j] = 0;
                for (int k = 0; k < K; k++) cm[i][j] += am[i][k] * bm[k][j];
            end
    endtask

    task automatic check_c(input string tag, input bit zero);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                chk($sformatf("%s C[%0d][%0d]", tag, i, j), res[i][j], zero ? 32'd0 : cm[i][j]);
    endtask

    task automatic zero_in();
        for (int i = 0; i < H; i++) act[i] = 0;
        for (int j = 0; j < W; j++) wt[j] = 0;
    endtask

    task automatic drive(input int n);
        @(negedge clk);
        start = 0;
        for (int i = 0; i < H; i++) act[i] = (n - i >= 0 && n - i < K) ? am[i][n-i] : 32'd0;
        for (int j = 0; j < W; j++) wt[j] = (n - j >= 0 && n - j < K) ? bm[n-j][j] : 32'd0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1;
        zero_in();
    endtask

    task automatic mult();
        start_pulse();
        for (int n = 0; n <= LAST_N; n++) drive(n);
        @(negedge clk);
        zero_in();
    endtask

    task automatic fill_default();
        for (int i = 0; i < H; i++)
            for (int k = 0; k < K; k++) am[i][k] = i + k + 1;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < W; j++) bm[k][j] = k + j + 1;
        model();
    endtask

    initial begin
        vec_t  tv [0:6];
        spot_t sp [0:3];
        tv[0] = '{1'b1, 8'd9,   8'd9,   8'd0};
        tv[1] = '{1'b0, 8'd16,  8'd16,  8'd0};
        tv[2] = '{1'b0, 8'd3,   8'd5,   8'd15};
        tv[3] = '{1'b0, 8'd0,   8'd0,   8'd15};
        tv[4] = '{1'b0, 8'd255, 8'd255, 8'd16};
        tv[5] = '{1'b1, 8'd7,   8'd7,   8'd0};
        tv[6] = '{1'b0, 8'd2,   8'd2,   8'd4};
        sp[0] = '{0, 0, 55};
        sp[1] = '{0, 1, 70};
        sp[2] = '{1, 0, 70};
        sp[3] = '{9, 6, 550};
        zero_in();
        s_act[0] = 0;
        s_wt[0]  = 0;
        #1 rstn = 0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < H; i++) act[i] = $urandom;
            for (int j = 0; j < W; j++) wt[j] = $urandom;
        end
        @(negedge clk);
        check_c("reset", 1'b1);
        zero_in();
        rstn = 1;
        repeat (3) @(negedge clk);
        check_c("post_reset", 1'b1);
        for (int v = 0; v < 7; v++) begin
            s_start  = tv[v].st;
            s_act[0] = tv[v].a;
            s_wt[0]  = tv[v].w;
            @(negedge clk);
            chk($sformatf("wrap vec%0d", v), {24'd0, s_res[0][0]}, {24'd0, tv[v].exp});
        end
        s_start  = 0;
        s_act[0] = 0;
        s_wt[0]  = 0;
        fill_default();
        mult();
        for (int s = 0; s < 4; s++)
            chk($sformatf("spot C[%0d][%0d]", sp[s].i, sp[s].j), res[sp[s].i][sp[s].j], sp[s].exp);
        check_c("mult", 1'b0);
        repeat (500) @(negedge clk);
        check_c("hold", 1'b0);
        start_pulse();
        @(negedge clk);
        start = 0;
        check_c("start_clear", 1'b1);
        for (int i = 0; i < H; i++)
            for (int k = 0; k < K; k++) am[i][k] = 1;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < W; j++) bm[k][j] = 2;
        model();
        mult();
        chk("ones_twos C[4][3]", res[4][3], 32'd10);
        check_c("ones_twos", 1'b0);
        @(negedge clk);
        start = 1;
        for (int i = 0; i < H; i++) act[i] = 5;
        for (int j = 0; j < W; j++) wt[j] = 3;
        @(negedge clk);
        start = 0;
        zero_in();
        check_c("start_active", 1'b1);
        @(negedge clk);
        check_c("start_active_next", 1'b1);
        fill_default();
        start_pulse();
        for (int n = 0; n <= 3; n++) drive(n);
        #2 rstn = 0;
        #1 check_c("mid_reset", 1'b1);
        @(negedge clk);
        zero_in();
        rstn = 1;
        mult();
        check_c("after_mid_reset", 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
